// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_pkg                                             |
// | Description : Shared constants, writeback request type and register   |
// |               one-hot decode for the register file writeback path.    |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package regfile_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] regnum;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] onehot_reg(input logic [REG_AW-1:0] regnum);
        logic [NUM_REGS-1:0] decode;
        decode         = '0;
        decode[regnum] = 1'b1;
        return decode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_rr_arbiter                                           |
// | Description : One-of-NUM_REQ grant over full writeback buffers.       |
// |               WB_RR_ARB_EN selects round-robin, else fixed priority.  |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module wb_rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grantIdx
);

`ifdef WB_RR_ARB_EN
    logic [2:0] r_ptr;

    // Descending scan so the smallest offset from the pointer is assigned last and wins.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req[(int'(r_ptr) + off) % NUM_REQ]) begin
                grant                                   = '0;
                grant[(int'(r_ptr) + off) % NUM_REQ]    = 1'b1;
                grantIdx                                = 3'((int'(r_ptr) + off) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_ptr <= 3'd0;
        end else if (advance) begin
            r_ptr <= (int'(grantIdx) == NUM_REQ - 1) ? 3'd0 : grantIdx + 3'd1;
        end
    end
`else
    logic w_unusedInputs;
    assign w_unusedInputs = ^{clk, Reset, advance};

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                grantIdx = 3'(i);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : regfile_wb_arbiter                                      |
// | Description : Shares the register file write port among NUM_REQ       |
// |               buffered writeback sources; publishes in-flight mask.   |
// |               Arbitration mode selected by macro WB_RR_ARB_EN.        |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*REG_AW-1:0] req_regnum,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      RegWrite,
    output logic [REG_AW-1:0]         WriteRegNum,
    output logic [DATA_W-1:0]         WriteData,
    output logic [31:0]               pending_mask,
    output logic [2:0]                grant_idx
);
    import regfile_pkg::*;

    logic [NUM_REQ-1:0] r_bufFull;
    logic [REG_AW-1:0]  r_bufReg  [NUM_REQ];
    logic [DATA_W-1:0]  r_bufData [NUM_REQ];

    logic               r_regWrite;
    logic [REG_AW-1:0]  r_writeRegNum;
    logic [DATA_W-1:0]  r_writeData;
    logic [2:0]         r_grantIdx;

    logic [NUM_REQ-1:0] w_grant;
    logic [2:0]         w_grantIdx;
    logic               w_anyGrant;
    logic [REG_AW-1:0]  w_selReg;
    logic [DATA_W-1:0]  w_selData;
    logic [31:0]        w_pending;

    wb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk      (clk),
        .Reset    (Reset),
        .req      (r_bufFull),
        .advance  (w_anyGrant),
        .grant    (w_grant),
        .grantIdx (w_grantIdx)
    );

    assign w_anyGrant = |w_grant;
    // A draining buffer can take a new entry on the same edge.
    assign req_ready  = ~r_bufFull | w_grant;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_buf
            always_ff @(posedge clk) begin
                if (Reset) begin
                    r_bufFull[gi] <= 1'b0;
                end else if (req_valid[gi] && req_ready[gi]) begin
                    r_bufFull[gi] <= 1'b1;
                end else if (w_grant[gi]) begin
                    r_bufFull[gi] <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (req_valid[gi] && req_ready[gi]) begin
                    r_bufReg[gi]  <= req_regnum[gi*REG_AW +: REG_AW];
                    r_bufData[gi] <= req_data[gi*DATA_W +: DATA_W];
                end
            end
        end
    endgenerate

    always_comb begin
        w_selReg  = '0;
        w_selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_selReg  = r_bufReg[i];
                w_selData = r_bufData[i];
            end
        end
    end

    // Writes to r0 still consume a grant but never assert the write enable.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_regWrite    <= 1'b0;
            r_writeRegNum <= '0;
            r_writeData   <= '0;
            r_grantIdx    <= 3'd0;
        end else begin
            r_regWrite <= w_anyGrant && (w_selReg != '0);
            if (w_anyGrant) begin
                r_writeRegNum <= w_selReg;
                r_writeData   <= w_selData;
                r_grantIdx    <= w_grantIdx;
            end
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_bufFull[i]) begin
                w_pending = w_pending | onehot_reg(r_bufReg[i]);
            end
        end
        if (r_regWrite) begin
            w_pending = w_pending | onehot_reg(r_writeRegNum);
        end
        w_pending[0] = 1'b0;
    end

    assign RegWrite     = r_regWrite;
    assign WriteRegNum  = r_writeRegNum;
    assign WriteData    = r_writeData;
    assign grant_idx    = r_grantIdx;
    assign pending_mask = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_regfile_wb_arbiter                                   |
// | Description : Vector table plus directed sequences for the writeback  |
// |               arbiter; expectations follow WB_RR_ARB_EN.              |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        Reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_regnum;
    logic [95:0] req_data;
    logic        RegWrite;
    logic [4:0]  WriteRegNum;
    logic [31:0] WriteData;
    logic [31:0] pending_mask;
    logic [2:0]  grant_idx;

    int nTests = 0;
    int nFail  = 0;

    logic [31:0] rf [32];

    regfile_wb_arbiter #(
        .NUM_REQ (3),
        .DATA_W  (32),
        .REG_AW  (5)
    ) dut (
        .clk          (clk),
        .Reset        (Reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_regnum   (req_regnum),
        .req_data     (req_data),
        .RegWrite     (RegWrite),
        .WriteRegNum  (WriteRegNum),
        .WriteData    (WriteData),
        .pending_mask (pending_mask),
        .grant_idx    (grant_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RegWrite === 1'b1) rf[WriteRegNum] <= WriteData;
    end

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [4:0]  rn0, rn1, rn2;
        logic [31:0] d0, d1, d2;
        logic        eWr;
        logic [4:0]  eRn;
        logic [31:0] eData;
        logic [31:0] ePend;
        logic [2:0]  eReady;
        logic [2:0]  eGidx;
        logic        chkWd;
    } vec_t;

    vec_t vecs [16];

`ifdef WB_RR_ARB_EN
    localparam logic [31:0] SR_FIRST_D  = 32'h22;
    localparam logic [31:0] SR_SECOND_D = 32'h11;
    localparam logic [2:0]  SR_FIRST_G  = 3'd1;
    localparam logic [2:0]  SR_SECOND_G = 3'd0;
`else
    localparam logic [31:0] SR_FIRST_D  = 32'h11;
    localparam logic [31:0] SR_SECOND_D = 32'h22;
    localparam logic [2:0]  SR_FIRST_G  = 3'd0;
    localparam logic [2:0]  SR_SECOND_G = 3'd1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2);
        req_valid  = v;
        req_regnum = {r2, r1, r0};
        req_data   = {a2, a1, a0};
    endtask

    task automatic expectWrite(input string tag, input logic [4:0] rn, input logic [31:0] d,
                               input logic [2:0] g);
        check({tag, "_RegWrite"}, 32'(RegWrite), 32'd1);
        check({tag, "_WriteRegNum"}, 32'(WriteRegNum), 32'(rn));
        check({tag, "_WriteData"}, WriteData, d);
        check({tag, "_grant_idx"}, 32'(grant_idx), 32'(g));
    endtask

    // All three requesters hand over r1..r3 on the same edge.
    task automatic contentionRound(input logic [31:0] base);
        drive(3'b111, 5'd1, 5'd2, 5'd3, base + 1, base + 2, base + 3);
        step();
        check("cont_pending", pending_mask, 32'h0000_000E);
        check("cont_ready", 32'(req_ready), 32'h1);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        for (int j = 0; j < 3; j++) begin
            step();
            expectWrite($sformatf("cont_w%0d", j), 5'(j + 1), base + 32'(j + 1), 3'(j));
        end
        step();
        check("cont_idle_RegWrite", 32'(RegWrite), 32'd0);
        check("cont_idle_pending", pending_mask, 32'd0);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        Reset = 1'b1;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0);

        // rst valid rn0 rn1 rn2 d0 d1 d2 | eWr eRn eData ePend eReady eGidx chkWd
        vecs[0]  = '{1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,  32'h0,   1'b0, 5'd0, 32'h0,    32'h0,   3'b111, 3'd0, 1'b1};
        vecs[1]  = '{1'b0, 3'b010, 5'd0, 5'd9, 5'd0, 32'h0,    32'hAA, 32'h0,   1'b0, 5'd0, 32'h0,    32'h200, 3'b111, 3'd0, 1'b1};
        vecs[2]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,  32'h0,   1'b1, 5'd9, 32'hAA,   32'h200, 3'b111, 3'd1, 1'b1};
        vecs[3]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,  32'h0,   1'b0, 5'd9, 32'hAA,   32'h0,   3'b111, 3'd1, 1'b1};
        vecs[4]  = '{1'b0, 3'b001, 5'd0, 5'd0, 5'd0, 32'hDEAD, 32'h0,  32'h0,   1'b0, 5'd9, 32'hAA,   32'h0,   3'b111, 3'd1, 1'b1};
        vecs[5]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,  32'h0,   1'b0, 5'd0, 32'h0,    32'h0,   3'b111, 3'd0, 1'b0};
        vecs[6]  = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,  32'h0,   1'b0, 5'd0, 32'h0,    32'h0,   3'b111, 3'd0, 1'b0};
        vecs[7]  = '{1'b0, 3'b100, 5'd0, 5'd0, 5'd4, 32'h0,    32'h0,  32'h104, 1'b0, 5'd0, 32'h0,    32'h10,  3'b111, 3'd0, 1'b0};
        vecs[8]  = '{1'b0, 3'b100, 5'd0, 5'd0, 5'd5, 32'h0,    32'h0,  32'h105, 1'b1, 5'd4, 32'h104,  32'h30,  3'b111, 3'd2, 1'b1};
        vecs[9]  = '{1'b0, 3'b100, 5'd0, 5'd0, 5'd6, 32'h0,    32'h0,  32'h106, 1'b1, 5'd5, 32'h105,  32'h60,  3'b111, 3'd2, 1'b1};
        vecs[10] = '{1'b0, 3'b100, 5'd0, 5'd0, 5'd7, 32'h0,    32'h0,  32'h107, 1'b1, 5'd6, 32'h106,  32'hC0,  3'b111, 3'd2, 1'b1};
        vecs[11] = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,  32'h0,   1'b1, 5'd7, 32'h107,  32'h80,  3'b111, 3'd2, 1'b1};
        vecs[12] = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,  32'h0,   1'b0, 5'd7, 32'h107,  32'h0,   3'b111, 3'd2, 1'b1};
        vecs[13] = '{1'b0, 3'b101, 5'd5, 5'd0, 5'd7, 32'h55,   32'h0,  32'h77,  1'b0, 5'd7, 32'h107,  32'hA0,  3'b011, 3'd2, 1'b1};
        vecs[14] = '{1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,  32'h0,   1'b0, 5'd0, 32'h0,    32'h0,   3'b111, 3'd0, 1'b1};
        vecs[15] = '{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,    32'h0,  32'h0,   1'b0, 5'd0, 32'h0,    32'h0,   3'b111, 3'd0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            Reset = vecs[i].rst;
            drive(vecs[i].valid, vecs[i].rn0, vecs[i].rn1, vecs[i].rn2,
                  vecs[i].d0, vecs[i].d1, vecs[i].d2);
            step();
            check($sformatf("v%0d_RegWrite", i), 32'(RegWrite), 32'(vecs[i].eWr));
            check($sformatf("v%0d_pending", i), pending_mask, vecs[i].ePend);
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].eReady));
            if (vecs[i].chkWd) begin
                check($sformatf("v%0d_WriteRegNum", i), 32'(WriteRegNum), 32'(vecs[i].eRn));
                check($sformatf("v%0d_WriteData", i), WriteData, vecs[i].eData);
                check($sformatf("v%0d_grant_idx", i), 32'(grant_idx), 32'(vecs[i].eGidx));
            end
        end
        Reset = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0);

        contentionRound(32'hA0);
`ifdef WB_RR_ARB_EN
        contentionRound(32'hB0);
`else
        // Requester 0 refilled every cycle keeps requester 2 starved.
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hC0, 32'hC1, 32'hC2);
        step();
        for (int n = 0; n < 6; n++) begin
            drive(3'b001, 5'd1, 5'd0, 5'd0, 32'hD0 + 32'(n), 0, 0);
            step();
            expectWrite($sformatf("starve%0d", n), 5'd1,
                        (n == 0) ? 32'hC0 : 32'hD0 + 32'(n - 1), 3'd0);
            check($sformatf("starve%0d_ready2", n), 32'(req_ready[2]), 32'd0);
            check($sformatf("starve%0d_pend3", n), 32'(pending_mask[3]), 32'd1);
        end
        drive(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step();
        expectWrite("starve_tail0", 5'd1, 32'hD5, 3'd0);
        step();
        expectWrite("starve_tail1", 5'd2, 32'hC1, 3'd1);
        step();
        expectWrite("starve_tail2", 5'd3, 32'hC2, 3'd2);
        step();
        check("starve_idle_pending", pending_mask, 32'd0);
`endif

        // Same-register ordering; a lone grant to requester 0 leaves the RR pointer at 1.
        drive(3'b001, 5'd20, 5'd0, 5'd0, 32'h5, 0, 0);
        step();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step();
        expectWrite("prime", 5'd20, 32'h5, 3'd0);
        step();
        drive(3'b011, 5'd12, 5'd12, 5'd0, 32'h11, 32'h22, 0);
        step();
        check("same_pend_acc", 32'(pending_mask[12]), 32'd1);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step();
        expectWrite("same_first", 5'd12, SR_FIRST_D, SR_FIRST_G);
        check("same_pend_first", 32'(pending_mask[12]), 32'd1);
        step();
        expectWrite("same_second", 5'd12, SR_SECOND_D, SR_SECOND_G);
        check("same_pend_second", 32'(pending_mask[12]), 32'd1);
        step();
        check("same_idle_RegWrite", 32'(RegWrite), 32'd0);
        check("same_pend_clear", 32'(pending_mask[12]), 32'd0);
        check("same_rf12", rf[12], SR_SECOND_D);

        check("rf0", rf[0], 32'd0);
        check("rf5", rf[5], 32'h105);
        check("rf7", rf[7], 32'h107);
        check("rf9", rf[9], 32'hAA);
        check("rf20", rf[20], 32'h5);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
